// File: rtl/button_bank_if.sv
// Button bank pin/event bundle: raw pins in, debounced level and event pulses out.
// Latency: n/a (signal container only).
// Backpressure: none; every output is a level or a one-cycle strobe.
// The release and repeat strobes are named rls and rpt because the plain words are SV keywords.
interface button_bank_if #(
    parameter int N = 4
);
    logic [N-1:0] btn;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rls;
    logic [N-1:0] hold;
    logic [N-1:0] rpt;
    logic         tick;

    // Pin driver side
    modport master (
        output btn,
        input  level, press, rls, hold, rpt, tick
    );

    // Debouncer side
    modport slave (
        input  btn,
        output level, press, rls, hold, rpt, tick
    );
endinterface

// File: rtl/button_bank.sv
// N-channel push-button debouncer with a shared sample-tick prescaler, press/release/hold pulses.
// Latency: 2 clk sync plus DB_COUNT ticks to a level change; events are registered with the level.
// Backpressure: none; pulses are one cycle wide and never stall. Auto-repeat built under BUTTON_BANK_REPEAT_EN.
module button_bank #(
    parameter int N            = 4,
    parameter bit ACTIVE_LOW   = 1'b0,
    parameter int TICK_DIV     = 131072,
    parameter int DB_COUNT     = 7,
    parameter int HOLD_TICKS   = 64,
    parameter int REPEAT_TICKS = 16
) (
    input logic           clk,
    input logic           reset_n,
    button_bank_if.slave  bus
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DB_W   = $clog2(DB_COUNT + 1);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic [TICK_W-1:0] div_q, div_d;
    logic              tick_q, tick_d;

    logic [N-1:0] pin_norm;
    logic [N-1:0] sync1_q, sync2_q;
    logic [N-1:0] level_q, level_d;
    logic [N-1:0] press_q, press_d;
    logic [N-1:0] rls_q, rls_d;
    logic [N-1:0] hold_q, hold_d;
    logic [DB_W-1:0]   db_q   [N];
    logic [DB_W-1:0]   db_d   [N];
    logic [HOLD_W-1:0] hcnt_q [N];
    logic [HOLD_W-1:0] hcnt_d [N];

`ifdef BUTTON_BANK_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
    logic [N-1:0]     rpt_q, rpt_d;
    logic [REP_W-1:0] rcnt_q [N];
    logic [REP_W-1:0] rcnt_d [N];
`else
    // Repeat period only matters when auto-repeat is built; keep it referenced.
    localparam bit REP_CFG_OK = (REPEAT_TICKS >= 1);
`endif

    // Pressed reads as 1 from here on, whatever the pin polarity.
    assign pin_norm = ACTIVE_LOW ? ~bus.btn : bus.btn;

    // Prescaler: strobe when the count hits its last value; the strobe and state updates share that edge.
    always_comb begin
        tick_d = (div_q == TICK_LAST);
        div_d  = tick_d ? '0 : div_q + 1'b1;
    end

    // Per-channel debounce, edge detection, hold and auto-repeat counters.
    always_comb begin
        level_d = level_q;
        press_d = '0;
        rls_d   = '0;
        hold_d  = '0;
        db_d    = db_q;
        hcnt_d  = hcnt_q;
`ifdef BUTTON_BANK_REPEAT_EN
        rpt_d   = '0;
        rcnt_d  = rcnt_q;
`endif
        for (int i = 0; i < N; i++) begin
            if (tick_d) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (db_q[i] == DB_LAST) begin
                        level_d[i] = ~level_q[i];
                        db_d[i]    = '0;
                        press_d[i] = ~level_q[i];
                        rls_d[i]   = level_q[i];
                    end else begin
                        db_d[i] = db_q[i] + 1'b1;
                    end
                end else begin
                    // One agreeing sample throws away all progress.
                    db_d[i] = '0;
                end
            end
            // A level change restarts the hold count and suppresses hold/repeat in that cycle.
            if (press_d[i] || rls_d[i]) begin
                hcnt_d[i] = '0;
            end else if (tick_d && level_q[i] && (hcnt_q[i] != HOLD_MAX)) begin
                hcnt_d[i] = hcnt_q[i] + 1'b1;
                hold_d[i] = (hcnt_q[i] == HOLD_LAST);
            end
`ifdef BUTTON_BANK_REPEAT_EN
            // Repeat counting starts on the tick after hold, once the hold count has saturated.
            if (press_d[i] || rls_d[i] || hold_d[i]) begin
                rcnt_d[i] = '0;
            end else if (tick_d && level_q[i] && (hcnt_q[i] == HOLD_MAX)) begin
                if (rcnt_q[i] == REP_LAST) begin
                    rpt_d[i]  = 1'b1;
                    rcnt_d[i] = '0;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + 1'b1;
                end
            end
`endif
        end
    end

    // State registers; reset drops every output with no release pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            rls_q   <= '0;
            hold_q  <= '0;
            for (int i = 0; i < N; i++) begin
                db_q[i]   <= '0;
                hcnt_q[i] <= '0;
            end
`ifdef BUTTON_BANK_REPEAT_EN
            rpt_q <= '0;
            for (int i = 0; i < N; i++) begin
                rcnt_q[i] <= '0;
            end
`endif
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            sync1_q <= pin_norm;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            rls_q   <= rls_d;
            hold_q  <= hold_d;
            db_q    <= db_d;
            hcnt_q  <= hcnt_d;
`ifdef BUTTON_BANK_REPEAT_EN
            rpt_q   <= rpt_d;
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    assign bus.level = level_q;
    assign bus.press = press_q;
    assign bus.rls   = rls_q;
    assign bus.hold  = hold_q;
    assign bus.tick  = tick_q;
`ifdef BUTTON_BANK_REPEAT_EN
    assign bus.rpt   = rpt_q;
`else
    assign bus.rpt   = {N{1'b0}} & {N{REP_CFG_OK}};
`endif
endmodule

// File: tb/tb_button_bank.sv
// Randomized and directed stimulus for button_bank, checked by a scoreboard against a tick-level model.
// The model pushes predicted event cycles; a negedge monitor pops them when the DUT pulses.
// Bounded by fixed cycle counts; leftover predictions are reported at the end.
module tb_button_bank;
    localparam int N          = 2;
    localparam int TICK_DIV   = 4;
    localparam int DB_COUNT   = 3;
    localparam int HOLD_TICKS = 5;
    localparam int REP_TICKS  = 2;

    typedef struct {
        int         cyc;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
        logic [N-1:0] ho;
        logic [N-1:0] rp;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    button_bank_if #(.N(N)) bus ();

    button_bank #(
        .N(N), .ACTIVE_LOW(1'b0), .TICK_DIV(TICK_DIV), .DB_COUNT(DB_COUNT),
        .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REP_TICKS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ev_t          sb[$];
    int           m_cyc;
    logic         m_tick;
    logic [N-1:0] m_lvl;
    logic [N-1:0] s1, s2;
    bit           win [N][$];
    int           tsp [N];

    always @(posedge clk or negedge reset_n) begin
        logic [N-1:0] synced, pr, rl, ho, rp;
        bit flip;
        if (!reset_n) begin
            m_cyc  = 0;
            m_tick = 1'b0;
            m_lvl  = '0;
            s1     = '0;
            s2     = '0;
            sb.delete();
            for (int c = 0; c < N; c++) begin
                win[c].delete();
                tsp[c] = 0;
            end
        end else begin
            m_cyc++;
            m_tick = (m_cyc % TICK_DIV) == 0;
            synced = s2;
            s2 = s1;
            s1 = bus.btn;
            pr = '0; rl = '0; ho = '0; rp = '0;
            if (m_tick) begin
                for (int c = 0; c < N; c++) begin
                    // Level flips once the last DB_COUNT tick samples all disagree with it.
                    win[c].push_back(synced[c]);
                    if (win[c].size() > DB_COUNT) void'(win[c].pop_front());
                    flip = (win[c].size() == DB_COUNT);
                    foreach (win[c][k]) if (win[c][k] == m_lvl[c]) flip = 0;
                    if (flip) begin
                        m_lvl[c] = ~m_lvl[c];
                        if (m_lvl[c]) begin
                            pr[c] = 1'b1;
                            tsp[c] = 0;
                        end else begin
                            rl[c] = 1'b1;
                        end
                    end else if (m_lvl[c]) begin
                        tsp[c]++;
                        if (tsp[c] == HOLD_TICKS) ho[c] = 1'b1;
`ifdef BUTTON_BANK_REPEAT_EN
                        if (tsp[c] > HOLD_TICKS && ((tsp[c] - HOLD_TICKS) % REP_TICKS) == 0)
                            rp[c] = 1'b1;
`endif
                    end
                end
            end
            if (|{pr, rl, ho, rp}) sb.push_back('{cyc: m_cyc, pr: pr, rl: rl, ho: ho, rp: rp});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ev_t e;
        if (reset_n) begin
            chk("tick", int'(bus.tick), int'(m_tick));
            chk("level", int'(bus.level), int'(m_lvl));
            while (sb.size() != 0 && sb[0].cyc < m_cyc) begin
                chk("missing_event_cycle", m_cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (|{bus.press, bus.rls, bus.hold, bus.rpt}) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", int'({bus.press, bus.rls, bus.hold, bus.rpt}), 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_cycle", m_cyc, e.cyc);
                    chk("press", int'(bus.press), int'(e.pr));
                    chk("release", int'(bus.rls), int'(e.rl));
                    chk("hold", int'(bus.hold), int'(e.ho));
                    chk("repeat", int'(bus.rpt), int'(e.rp));
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_level"}, int'(bus.level), 0);
        chk({tag, "_press"}, int'(bus.press), 0);
        chk({tag, "_release"}, int'(bus.rls), 0);
        chk({tag, "_hold"}, int'(bus.hold), 0);
        chk({tag, "_repeat"}, int'(bus.rpt), 0);
        chk({tag, "_tick"}, int'(bus.tick), 0);
    endtask

    initial begin
        bus.btn = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Idle: only the tick strobe moves.
        wait_cycles(20);

        // Clean press on ch0, held 40 cycles, then release.
        bus.btn = 2'b01;
        wait_cycles(40);
        bus.btn = 2'b00;
        wait_cycles(30);

        // Bounce on ch0: high 2 ticks, low 1 tick, then steady.
        bus.btn = 2'b01;
        wait_cycles(2 * TICK_DIV);
        bus.btn = 2'b00;
        wait_cycles(TICK_DIV);
        bus.btn = 2'b01;
        wait_cycles(40);
        bus.btn = 2'b00;
        wait_cycles(30);

        // Long hold on ch1 for repeat behaviour.
        bus.btn = 2'b10;
        wait_cycles((DB_COUNT + 13) * TICK_DIV + 4);
        bus.btn = 2'b00;
        wait_cycles(30);

        // Reset while ch0 is held, then re-press after reset.
        bus.btn = 2'b01;
        wait_cycles(40);
        #1 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        #1 reset_n = 1'b1;
        wait_cycles(2 + DB_COUNT * TICK_DIV + 4);
        chk("repress_level", int'(bus.level), 1);
        wait_cycles(10);
        bus.btn = 2'b00;
        wait_cycles(30);

        // Random pin activity on both channels.
        for (int it = 0; it < 250; it++) begin
            bus.btn = 2'($urandom_range(0, 3));
            wait_cycles($urandom_range(1, 45));
        end
        bus.btn = 2'b00;
        wait_cycles(40);

        while (sb.size() != 0) begin
            chk("leftover_event_cycle", m_cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
